// File: rtl/instr_register_pkg.sv
// -----------------------------------------------------------------------------
// instr_register_pkg
// Shared types for the instruction register and its sequential reader:
//   opcode_t, operand_t, instruction_t  - instruction register contents
//   reader_state_t                      - instr_reader state encoding
//   result_t                            - signed 64-bit evaluation result
// -----------------------------------------------------------------------------
package instr_register_pkg;

   localparam int OPERAND_W = 32;
   localparam int RESULT_W  = 64;

   typedef enum logic [3:0] {
      ZERO  = 4'd0,
      PASSA = 4'd1,
      PASSB = 4'd2,
      ADD   = 4'd3,
      SUB   = 4'd4,
      MULT  = 4'd5,
      DIV   = 4'd6,
      MOD   = 4'd7
   } opcode_t;

   typedef logic signed [OPERAND_W-1:0] operand_t;

   typedef struct packed {
      opcode_t  opc;
      operand_t op_a;
      operand_t op_b;
   } instruction_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      HOLD  = 2'd2,
      DONE  = 2'd3
   } reader_state_t;

   typedef logic signed [RESULT_W-1:0] result_t;

endpackage

// File: rtl/instr_alu.sv
// -----------------------------------------------------------------------------
// instr_alu
// Combinational evaluator for one instruction word.
//   instr  in  instruction_t  opcode and two signed 32-bit operands
//   result out result_t       signed 64-bit result
//   err    out 1              result invalid (divide by zero / divider absent)
// Build option: INSTR_READER_DIV_EN defined -> DIV/MOD implemented; undefined
// -> no divider, DIV/MOD return 0 with err set.
// -----------------------------------------------------------------------------
module instr_alu
   import instr_register_pkg::*;
(
   input  instruction_t instr,
   output result_t      result,
   output logic         err
);

   result_t a64;
   result_t b64;

   // Operands widened first so ADD/SUB/MULT cannot overflow and the
   // -2^31 / -1 quotient is representable.
   assign a64 = {{(RESULT_W-OPERAND_W){instr.op_a[OPERAND_W-1]}}, instr.op_a};
   assign b64 = {{(RESULT_W-OPERAND_W){instr.op_b[OPERAND_W-1]}}, instr.op_b};

   always_comb begin
      result = '0;
      err    = 1'b0;
      case (instr.opc)
         ZERO:  result = '0;
         PASSA: result = a64;
         PASSB: result = b64;
         ADD:   result = a64 + b64;
         SUB:   result = a64 - b64;
         MULT:  result = a64 * b64;
`ifdef INSTR_READER_DIV_EN
         DIV: begin
            if (instr.op_b == '0) err = 1'b1;
            else                  result = a64 / b64;
         end
         MOD: begin
            if (instr.op_b == '0) err = 1'b1;
            else                  result = a64 % b64;
         end
`else
         DIV:   err = 1'b1;
         MOD:   err = 1'b1;
`endif
         default: result = '0;
      endcase
   end

endmodule

// File: rtl/instr_reader.sv
// -----------------------------------------------------------------------------
// instr_reader
// Walks read_pointer over a contiguous (wrapping) run of instruction register
// locations, evaluates each instruction and streams the results out.
//   clk, reset_n        clock, synchronous active-low reset
//   start, first_ptr,   run request and its parameters (sampled in IDLE only)
//   count
//   read_pointer        registered address into the instruction register
//   instruction_word    combinational read data for read_pointer
//   res_valid/res_ready result handshake
//   res_data/res_ptr/   result, source location, opcode, error flag
//   res_opc/res_err
//   busy                high in FETCH and HOLD
//   done                one-cycle pulse after the final handshake
// Build option: INSTR_READER_DIV_EN (see instr_alu) enables DIV/MOD.
// -----------------------------------------------------------------------------
module instr_reader
   import instr_register_pkg::*;
#(
   parameter int NUM_ENTRIES = 32,
   localparam int AW = $clog2(NUM_ENTRIES)
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          start,
   input  logic [AW-1:0] first_ptr,
   input  logic [AW:0]   count,
   output logic [AW-1:0] read_pointer,
   input  instruction_t  instruction_word,
   output logic          res_valid,
   input  logic          res_ready,
   output result_t       res_data,
   output logic [AW-1:0] res_ptr,
   output opcode_t       res_opc,
   output logic          res_err,
   output logic          busy,
   output logic          done
);

   reader_state_t state_q, state_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   remaining_q, remaining_d;
   logic          res_valid_q, res_valid_d;
   result_t       res_data_q, res_data_d;
   logic [AW-1:0] res_ptr_q, res_ptr_d;
   opcode_t       res_opc_q, res_opc_d;
   logic          res_err_q, res_err_d;

   result_t       alu_result;
   logic          alu_err;

   instr_alu u_alu (
      .instr  (instruction_word),
      .result (alu_result),
      .err    (alu_err)
   );

   always_comb begin
      state_d     = state_q;
      rd_ptr_d    = rd_ptr_q;
      remaining_d = remaining_q;
      res_valid_d = res_valid_q;
      res_data_d  = res_data_q;
      res_ptr_d   = res_ptr_q;
      res_opc_d   = res_opc_q;
      res_err_d   = res_err_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               if (count != '0) begin
                  rd_ptr_d    = first_ptr;
                  remaining_d = count;
                  state_d     = FETCH;
               end else begin
                  state_d = DONE;
               end
            end
         end
         FETCH: begin
            // Only cycle in which instruction_word is observed.
            res_data_d  = alu_result;
            res_err_d   = alu_err;
            res_opc_d   = instruction_word.opc;
            res_ptr_d   = rd_ptr_q;
            res_valid_d = 1'b1;
            state_d     = HOLD;
         end
         HOLD: begin
            if (res_valid_q && res_ready) begin
               res_valid_d = 1'b0;
               if (remaining_q == (AW+1)'(1)) begin
                  state_d = DONE;
               end else begin
                  remaining_d = remaining_q - (AW+1)'(1);
                  // Power-of-two depth: natural AW-bit overflow is the wrap.
                  rd_ptr_d    = rd_ptr_q + AW'(1);
                  state_d     = FETCH;
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         rd_ptr_q    <= '0;
         remaining_q <= '0;
         res_valid_q <= 1'b0;
         res_data_q  <= '0;
         res_ptr_q   <= '0;
         res_opc_q   <= ZERO;
         res_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         rd_ptr_q    <= rd_ptr_d;
         remaining_q <= remaining_d;
         res_valid_q <= res_valid_d;
         res_data_q  <= res_data_d;
         res_ptr_q   <= res_ptr_d;
         res_opc_q   <= res_opc_d;
         res_err_q   <= res_err_d;
      end
   end

   assign read_pointer = rd_ptr_q;
   assign res_valid    = res_valid_q;
   assign res_data     = res_data_q;
   assign res_ptr      = res_ptr_q;
   assign res_opc      = res_opc_q;
   assign res_err      = res_err_q;
   assign busy         = (state_q == FETCH) || (state_q == HOLD);
   assign done         = (state_q == DONE);

endmodule
